wb_timer: RTL and testbench

Wishbone slave programmable countdown timer that produces the CPU's `interrupt_request_i`. It replaces the free-running fixed-period counter on the system bus with a software-controlled periodic or one-shot timer and a latched interrupt. It sits beside `wb_ram` on the `cpu` Wishbone bus. An external address decoder gates `stb_i`.

---
 rtl/wb_timer.sv | 149 ++++++++++++++
 tb/tb_wb_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// Wishbone programmable countdown timer with periodic/one-shot modes and latched interrupt.
// Optional prescaler is compiled in when WB_TIMER_PRESCALER_EN is defined.
module wb_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        interrupt_request_o
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_en;
    logic             r_auto;
    logic             r_ie;
    logic             r_pend;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_count;

    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_reload;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_en_wr;
    logic        w_tick;
    logic        w_term;
    logic [31:0] w_reload_wd;
    logic [31:0] w_count_wd;
    logic [31:0] w_rdata;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // The ~r_ack term forces an idle cycle between back-to-back acks.
    assign w_access    = stb_i & cyc_i & ~r_ack;
    assign w_wr        = w_access & we_i;
    assign w_rd        = w_access & ~we_i;
    assign w_wr_ctrl   = w_wr & (adr_i == 3'd0);
    assign w_wr_reload = w_wr & (adr_i == 3'd1);
    assign w_wr_count  = w_wr & (adr_i == 3'd2);
    assign w_wr_status = w_wr & (adr_i == 3'd3);
    assign w_en_wr     = w_wr_ctrl & sel_i[0];

    assign w_reload_wd = f_merge(32'(r_reload), dat_i, sel_i);
    assign w_count_wd  = f_merge(32'(r_count), dat_i, sel_i);

`ifdef WB_TIMER_PRESCALER_EN
    logic [7:0] r_prescale;
    logic [7:0] r_pre_cnt;
    logic       w_wr_pre;

    assign w_wr_pre = w_wr & (adr_i == 3'd4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prescale <= 8'd0;
            r_pre_cnt  <= 8'd0;
        end else begin
            if (w_wr_pre && sel_i[0]) r_prescale <= dat_i[7:0];
            if (w_en_wr) begin
                r_pre_cnt <= 8'd0;
            end else if (r_en) begin
                r_pre_cnt <= (r_pre_cnt == 8'd0) ? r_prescale : r_pre_cnt - 8'd1;
            end
        end
    end

    assign w_tick = r_en & (r_pre_cnt == 8'd0);
`else
    assign w_tick = r_en;
`endif

    assign w_term = w_tick & (r_count == '0);

    always_comb begin
        w_rdata = 32'd0;
        case (adr_i)
            3'd0: w_rdata = {29'd0, r_ie, r_auto, r_en};
            3'd1: w_rdata = 32'(r_reload);
            3'd2: w_rdata = 32'(r_count);
            3'd3: w_rdata = {31'd0, r_pend};
`ifdef WB_TIMER_PRESCALER_EN
            3'd4: w_rdata = {24'd0, r_prescale};
`endif
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_ie     <= 1'b0;
            r_pend   <= 1'b0;
            r_reload <= '0;
            r_count  <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_rd ? w_rdata : 32'd0;

            // A bus write to EN overrides the one-shot auto-clear.
            if (w_en_wr) begin
                {r_ie, r_auto, r_en} <= dat_i[2:0];
            end else if (w_term && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_reload) r_reload <= w_reload_wd[WIDTH-1:0];

            if (w_wr_count) begin
                r_count <= w_count_wd[WIDTH-1:0];
            end else if (w_tick) begin
                if (r_count != '0) r_count <= r_count - WIDTH'(1);
                else if (r_auto)   r_count <= r_reload;
            end

            if (w_term) begin
                r_pend <= 1'b1;
            end else if (w_wr_status && sel_i[0] && dat_i[0]) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign ack_o               = r_ack;
    assign dat_o               = r_dat;
    assign interrupt_request_o = r_pend & r_ie;

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer; a second instance checks WIDTH=16 truncation.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  adr = 3'd0;
    logic [31:0] wdat = 32'd0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic [31:0] dat_o;
    logic        ack;
    logic        irq;
    logic [31:0] dat16;
    logic        ack16;
    logic        irq16;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_q    = 0;
    int last_edge;
    logic [31:0] rd;
    logic [31:0] rd16;

    wb_timer #(.WIDTH(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat_o), .we_i(we),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack), .interrupt_request_o(irq)
    );

    wb_timer #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat16), .we_i(we),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack16), .interrupt_request_o(irq16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_q <= cyc_q + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance so the next access is sampled on edge number 'target'.
    task automatic sync_to(input int target);
        while (cyc_q < target - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc_q;
        chk("write_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_read(input logic [2:0] a);
        adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc_q;
        chk("read_ack", {31'd0, ack}, 32'd1);
        rd = dat_o;
        rd16 = dat16;
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input int limit, output int at);
        at = -1000;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                at = cyc_q;
                return;
            end
        end
        chk("irq_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e0;
        int r1;
        int r2;

        idle(3);
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_dat", dat_o, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        idle(1);
        for (int w = 0; w < 8; w++) begin
            wb_read(3'(w));
            chk($sformatf("reset_word%0d", w), rd, 32'd0);
        end
        chk("dat_idle_zero", dat_o, 32'd0);
        chk("reset_irq_after_reads", {31'd0, irq}, 32'd0);

        // Periodic mode.
        wb_write(3'd1, 32'd50, 4'hF);
        wb_write(3'd2, 32'd50, 4'hF);
        wb_write(3'd0, 32'h7, 4'hF);
        e0 = last_edge;
        wait_irq(200, r1);
        chk("periodic_first", 32'(r1 - e0), 32'd51);
        wb_write(3'd3, 32'd1, 4'hF);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        wait_irq(200, r2);
        chk("periodic_second", 32'(r2 - r1), 32'd51);

        // One-shot mode.
        wb_write(3'd0, 32'h0, 4'hF);
        wb_write(3'd3, 32'd1, 4'hF);
        wb_write(3'd2, 32'd3, 4'hF);
        wb_write(3'd0, 32'h5, 4'hF);
        e0 = last_edge;
        wait_irq(50, r1);
        chk("oneshot_delay", 32'(r1 - e0), 32'd4);
        wb_read(3'd0);
        chk("oneshot_ctrl", rd, 32'h4);
        wb_read(3'd2);
        chk("oneshot_count", rd, 32'd0);
        wb_write(3'd3, 32'd1, 4'hF);
        idle(20);
        chk("oneshot_no_refire", {31'd0, irq}, 32'd0);
        wb_read(3'd3);
        chk("oneshot_pend_clr", rd, 32'd0);

        // Byte lanes and truncation.
        wb_write(3'd1, 32'd0, 4'hF);
        wb_write(3'd1, 32'hAABBCCDD, 4'b0101);
        wb_read(3'd1);
        chk("byte_lanes", rd, 32'h00BB00DD);
        wb_write(3'd1, 32'h12345678, 4'hF);
        wb_read(3'd1);
        chk("full_word", rd, 32'h12345678);
        chk("width16_trunc", rd16, 32'h00005678);
        wb_write(3'd0, 32'hFFFFFFF8, 4'hF);
        wb_read(3'd0);
        chk("ctrl_upper_zero", rd, 32'h0);
        wb_write(3'd6, 32'hFFFFFFFF, 4'hF);
        wb_read(3'd6);
        chk("word6_zero", rd, 32'd0);

        // STATUS clear collides with a terminal event.
        wb_write(3'd1, 32'd100, 4'hF);
        wb_write(3'd2, 32'd5, 4'hF);
        wb_write(3'd0, 32'h3, 4'hF);
        e0 = last_edge;
        sync_to(e0 + 6);
        wb_write(3'd3, 32'd1, 4'hF);
        chk("clr_collision_edge", 32'(last_edge - e0), 32'd6);
        wb_read(3'd3);
        chk("clr_collision_pend", rd, 32'd1);

        // COUNT write collides with a one-shot terminal event.
        wb_write(3'd0, 32'h0, 4'hF);
        wb_write(3'd3, 32'd1, 4'hF);
        wb_write(3'd2, 32'd2, 4'hF);
        wb_write(3'd0, 32'h1, 4'hF);
        e0 = last_edge;
        sync_to(e0 + 3);
        wb_write(3'd2, 32'd9, 4'hF);
        chk("cnt_collision_edge", 32'(last_edge - e0), 32'd3);
        wb_read(3'd2);
        chk("cnt_collision_count", rd, 32'd9);
        wb_read(3'd3);
        chk("cnt_collision_pend", rd, 32'd1);
        wb_read(3'd0);
        chk("cnt_collision_ctrl", rd, 32'h0);

        // CTRL write collides with a one-shot terminal event: written EN/AUTO persist.
        wb_write(3'd3, 32'd1, 4'hF);
        wb_write(3'd2, 32'd1, 4'hF);
        wb_write(3'd0, 32'h1, 4'hF);
        e0 = last_edge;
        sync_to(e0 + 2);
        wb_write(3'd0, 32'h3, 4'hF);
        chk("ctrl_collision_edge", 32'(last_edge - e0), 32'd2);
        wb_read(3'd0);
        chk("ctrl_collision_ctrl", rd, 32'h3);
        wb_read(3'd3);
        chk("ctrl_collision_pend", rd, 32'd1);
        wb_write(3'd0, 32'h0, 4'hF);
        wb_write(3'd3, 32'd1, 4'hF);

`ifdef WB_TIMER_PRESCALER_EN
        wb_write(3'd4, 32'd3, 4'hF);
        wb_read(3'd4);
        chk("prescale_rd", rd, 32'd3);
        wb_write(3'd1, 32'd4, 4'hF);
        wb_write(3'd2, 32'd4, 4'hF);
        wb_write(3'd0, 32'h7, 4'hF);
        wait_irq(100, r1);
        wb_write(3'd3, 32'd1, 4'hF);
        wait_irq(100, r2);
        chk("prescale_period", 32'(r2 - r1), 32'd20);
        wb_write(3'd0, 32'h0, 4'hF);
        wb_write(3'd3, 32'd1, 4'hF);
`else
        wb_write(3'd4, 32'hFF, 4'hF);
        wb_read(3'd4);
        chk("word4_zero", rd, 32'd0);
`endif

        // Reset during a write strobe aborts the access.
        wb_write(3'd1, 32'h0000_00AA, 4'hF);
        adr = 3'd1; wdat = 32'h0000_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_abort_ack", {31'd0, ack}, 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rst = 1'b0;
        idle(1);
        wb_read(3'd1);
        chk("rst_abort_reload", rd, 32'd0);
        chk("rst_abort_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
